// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and decode width shared by the GPIO peripheral.
package gpio_pkg;
  localparam int GPIO_ADDR_LSBS = 5;
  typedef logic [GPIO_ADDR_LSBS-1:0] gpio_ofs_t;
  localparam gpio_ofs_t GPIO_EN_OFS  = 5'h00;
  localparam gpio_ofs_t GPIO_IN_OFS  = 5'h04;
  localparam gpio_ofs_t GPIO_OUT_OFS = 5'h08;
  localparam gpio_ofs_t GPIO_SET_OFS = 5'h0C;
  localparam gpio_ofs_t GPIO_CLR_OFS = 5'h10;
endpackage

// File: rtl/apb_if.sv
// apb_if: APB bus bundle carrying the clock and asynchronous active-low reset.
interface apb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic arstn
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;
  modport slave (input clk, arstn, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                 output PRDATA, PREADY, PSLVERR);
  modport master (input clk, arstn, PRDATA, PREADY, PSLVERR,
                  output PSEL, PENABLE, PWRITE, PADDR, PWDATA);
endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: per-bit 2-flop synchronizer with asynchronous active-low reset.
module gpio_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/apb_gpio.sv
// apb_gpio: APB GPIO with enable, synchronized input, output data and set/clear aliases.
module apb_gpio
  import gpio_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  apb_if.slave                  apb_in,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [DATA_WIDTH-1:0] gpio_en
);
  gpio_ofs_t             ofs;
  logic                  access;
  logic                  wr;
  logic                  mapped;
  logic                  unused;
  logic [DATA_WIDTH-1:0] in_sync;
  assign ofs    = apb_in.PADDR[GPIO_ADDR_LSBS-1:0];
  // Upper address bits are decoded by the interconnect, not here.
  assign unused = ^apb_in.PADDR[ADDR_WIDTH-1:GPIO_ADDR_LSBS];
  assign access = apb_in.PSEL & apb_in.PENABLE;
  assign wr     = access & apb_in.PWRITE;
  assign mapped = ofs inside {GPIO_EN_OFS, GPIO_IN_OFS, GPIO_OUT_OFS, GPIO_SET_OFS, GPIO_CLR_OFS};
  assign apb_in.PREADY  = 1'b1;
  assign apb_in.PSLVERR = access & ~mapped;
  always_comb begin
    apb_in.PRDATA = '0;
    if (access & ~apb_in.PWRITE)
      apb_in.PRDATA = ofs == GPIO_EN_OFS  ? gpio_en :
                      ofs == GPIO_IN_OFS  ? in_sync :
                      ofs == GPIO_OUT_OFS ? gpio_out : '0;
  end
  gpio_sync #(.WIDTH(DATA_WIDTH)) u_sync (
    .clk  (apb_in.clk),
    .arstn(apb_in.arstn),
    .d    (gpio_in),
    .q    (in_sync)
  );
  always_ff @(posedge apb_in.clk or negedge apb_in.arstn)
    if (!apb_in.arstn) begin
      gpio_en  <= '0;
      gpio_out <= '0;
    end else if (wr) begin
      if (ofs == GPIO_EN_OFS) gpio_en <= apb_in.PWDATA;
      gpio_out <= ofs == GPIO_OUT_OFS ? apb_in.PWDATA :
                  ofs == GPIO_SET_OFS ? gpio_out | apb_in.PWDATA :
                  ofs == GPIO_CLR_OFS ? gpio_out & ~apb_in.PWDATA : gpio_out;
    end
endmodule

// File: tb/tb_apb_gpio.sv
// tb_apb_gpio: randomized APB traffic checked every cycle against a register-level model.
module tb_apb_gpio;
  import gpio_pkg::*;
  logic        clk = 0;
  logic        arstn = 1;
  logic [31:0] gpio_in = 0;
  logic [31:0] gpio_out, gpio_en;
  int          checks = 0, errors = 0;
  // Model: register contents plus the pin levels seen at the last two edges.
  logic [31:0] en_m = 0, out_m = 0, seen_last = 0, seen_prev = 0;
  logic [31:0] rd;
  logic        er;

  apb_if bus (.clk(clk), .arstn(arstn));
  apb_gpio dut (.apb_in(bus), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_en(gpio_en));

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk or negedge arstn)
    if (!arstn) begin
      en_m = 0; out_m = 0; seen_last = 0; seen_prev = 0;
    end else begin
      seen_prev = seen_last;
      seen_last = gpio_in;
      if (bus.PSEL && bus.PENABLE && bus.PWRITE)
        case (bus.PADDR[4:0])
          5'h00: en_m = bus.PWDATA;
          5'h08: out_m = bus.PWDATA;
          5'h0C: out_m = out_m | bus.PWDATA;
          5'h10: out_m = out_m & ~bus.PWDATA;
          default: ;
        endcase
    end

  always @(negedge clk) begin
    logic [31:0] rd_exp;
    logic        acc, known;
    acc = bus.PSEL && bus.PENABLE;
    known = bus.PADDR[4:0] inside {5'h00, 5'h04, 5'h08, 5'h0C, 5'h10};
    rd_exp = 0;
    if (acc && !bus.PWRITE)
      case (bus.PADDR[4:0])
        5'h00: rd_exp = en_m;
        5'h04: rd_exp = seen_prev;
        5'h08: rd_exp = out_m;
        default: rd_exp = 0;
      endcase
    check("gpio_out", gpio_out, out_m);
    check("gpio_en", gpio_en, en_m);
    check("prdata", bus.PRDATA, rd_exp);
    check("pslverr", {31'b0, bus.PSLVERR}, {31'b0, acc && !known});
    check("pready", {31'b0, bus.PREADY}, 32'd1);
  end

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output logic err);
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = w; bus.PADDR = a; bus.PWDATA = d;
    @(posedge clk); #1 bus.PENABLE = 1;
    @(negedge clk); rdata = bus.PRDATA; err = bus.PSLVERR;
    @(posedge clk); #1 bus.PENABLE = 0; bus.PSEL = 0;
  endtask

  initial begin
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
    #2 arstn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", gpio_out, 32'h0);
    check("rst_en", gpio_en, 32'h0);
    check("rst_prdata", bus.PRDATA, 32'h0);
    check("rst_pready", {31'b0, bus.PREADY}, 32'd1);
    @(posedge clk); #1 arstn = 1;
    @(posedge clk); #1;

    xfer(1, 32'h00, 32'hFFFF_FFFF, rd, er);
    check("wr_en", gpio_en, 32'hFFFF_FFFF);
    check("wr_en_err", {31'b0, er}, 32'd0);
    xfer(1, 32'h08, 32'hFFFF_FFFF, rd, er);
    check("wr_out", gpio_out, 32'hFFFF_FFFF);
    check("wr_out_err", {31'b0, er}, 32'd0);

    xfer(1, 32'h08, 32'h0000_00FF, rd, er);
    xfer(1, 32'h0C, 32'hF000_0000, rd, er);
    xfer(1, 32'h10, 32'h0000_000F, rd, er);
    check("set_clr", gpio_out, 32'hF000_00F0);
    xfer(0, 32'h08, 0, rd, er);
    check("rd_out", rd, 32'hF000_00F0);
    xfer(0, 32'h0C, 0, rd, er);
    check("rd_set", rd, 32'h0);

    gpio_in = 32'hA5A5_5A5A;
    xfer(0, 32'h04, 0, rd, er);
    check("rd_in_early", rd, 32'h0);
    xfer(0, 32'h04, 0, rd, er);
    check("rd_in", rd, 32'hA5A5_5A5A);

    xfer(1, 32'h14, 32'h1234_5678, rd, er);
    check("unmapped_wr_err", {31'b0, er}, 32'd1);
    check("unmapped_wr_out", gpio_out, 32'hF000_00F0);
    check("unmapped_wr_en", gpio_en, 32'hFFFF_FFFF);
    xfer(0, 32'h18, 0, rd, er);
    check("unmapped_rd_err", {31'b0, er}, 32'd1);
    check("unmapped_rd_data", rd, 32'h0);
    xfer(1, 32'h09, 32'h0, rd, er);
    check("misaligned_err", {31'b0, er}, 32'd1);
    check("misaligned_out", gpio_out, 32'hF000_00F0);
    xfer(1, 32'h04, 32'h0, rd, er);
    check("wr_in_err", {31'b0, er}, 32'd0);
    check("wr_in_out", gpio_out, 32'hF000_00F0);

    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 32'h08; bus.PWDATA = 32'h5555_5555;
    repeat (2) @(posedge clk);
    #1 bus.PSEL = 0; bus.PENABLE = 1;
    repeat (2) @(posedge clk);
    #1 bus.PENABLE = 0;
    check("no_access_out", gpio_out, 32'hF000_00F0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 2) == 0) gpio_in = $urandom;
      a = $urandom;
      a[4:0] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 9) == 0) begin
        bus.PSEL = 1'($urandom_range(0, 1)); bus.PENABLE = ~bus.PSEL;
        bus.PWRITE = 1; bus.PADDR = a; bus.PWDATA = $urandom;
        @(posedge clk); #1 bus.PSEL = 0; bus.PENABLE = 0;
      end else
        xfer(1'($urandom_range(0, 1)), a, $urandom, rd, er);
    end

    xfer(1, 32'h08, 32'h0F0F_0F0F, rd, er);
    xfer(1, 32'h00, 32'h3C3C_3C3C, rd, er);
    check("pre_rst_out", gpio_out, 32'h0F0F_0F0F);
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 32'h08; bus.PWDATA = 32'hDEAD_BEEF;
    @(posedge clk); #1 bus.PENABLE = 1;
    #2 arstn = 0;
    #1 check("midrst_out", gpio_out, 32'h0);
    check("midrst_en", gpio_en, 32'h0);
    @(posedge clk); #1 bus.PSEL = 0; bus.PENABLE = 0;
    @(posedge clk); #1 arstn = 1;
    repeat (2) @(posedge clk);
    #1 check("post_rst_out", gpio_out, 32'h0);
    check("post_rst_en", gpio_en, 32'h0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
